// File: rtl/multicycle_control.sv
// Multi-cycle MIPS controller: one state per cycle, drives every datapath select and
// write enable from the current state, the IR opcode, the ALU zero flag and memory ack.
module multicycle_control (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [5:0] Op_i,
    input  logic       Zero_i,
    input  logic       mem_ack_i,
    output logic       PCWrite_o,
    output logic       IorD_o,
    output logic       MemRead_o,
    output logic       MemWrite_o,
    output logic       IRWrite_o,
    output logic       RegDst_o,
    output logic       MemtoReg_o,
    output logic       RegWrite_o,
    output logic       ALUSrcA_o,
    output logic [1:0] ALUSrcB_o,
    output logic [1:0] ALUOp_o,
    output logic [1:0] PCSource_o,
    output logic       retired_o,
    output logic       illegal_o,
    output logic [3:0] state_o
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        MEMADDR  = 4'd3,
        MEMREAD  = 4'd4,
        MEMWB    = 4'd5,
        MEMWRITE = 4'd6,
        EXEC     = 4'd7,
        RWB      = 4'd8,
        BRANCH   = 4'd9,
        JUMP     = 4'd10,
        ADDI_EX  = 4'd11,
        ADDI_WB  = 4'd12
    } state_t;

    state_t state, state_nxt;
    state_t boundary;

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // Where a finished (or discarded) instruction hands off: straight into the next fetch
    // while running, otherwise park.
    assign boundary = start_i ? FETCH : IDLE;
    assign state_o  = state;

    always_comb begin
        state_nxt  = state;
        PCWrite_o  = 1'b0;
        IorD_o     = 1'b0;
        MemRead_o  = 1'b0;
        MemWrite_o = 1'b0;
        IRWrite_o  = 1'b0;
        RegDst_o   = 1'b0;
        MemtoReg_o = 1'b0;
        RegWrite_o = 1'b0;
        ALUSrcA_o  = 1'b0;
        ALUSrcB_o  = 2'b00;
        ALUOp_o    = 2'b00;
        PCSource_o = 2'b00;
        retired_o  = 1'b0;
        illegal_o  = 1'b0;

        case (state)
            IDLE: begin
                if (start_i) state_nxt = FETCH;
            end

            // PC+4 computed in the same cycle; PC and IR load only on the ack cycle.
            FETCH: begin
                MemRead_o = 1'b1;
                ALUSrcB_o = 2'b01;
                IRWrite_o = mem_ack_i;
                PCWrite_o = mem_ack_i;
                if (mem_ack_i) state_nxt = DECODE;
            end

            // Speculatively form the branch target into ALUOut.
            DECODE: begin
                ALUSrcB_o = 2'b11;
                case (Op_i)
                    OP_LW, OP_SW: state_nxt = MEMADDR;
                    OP_RTYPE:     state_nxt = EXEC;
                    OP_ADDI:      state_nxt = ADDI_EX;
                    OP_BEQ:       state_nxt = BRANCH;
                    OP_J:         state_nxt = JUMP;
                    default: begin
                        illegal_o = 1'b1;
                        state_nxt = boundary;
                    end
                endcase
            end

            MEMADDR: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = 2'b10;
                state_nxt = (Op_i == OP_LW) ? MEMREAD : MEMWRITE;
            end

            MEMREAD: begin
                MemRead_o = 1'b1;
                IorD_o    = 1'b1;
                if (mem_ack_i) state_nxt = MEMWB;
            end

            MEMWB: begin
                MemtoReg_o = 1'b1;
                RegWrite_o = 1'b1;
                retired_o  = 1'b1;
                state_nxt  = boundary;
            end

            MEMWRITE: begin
                MemWrite_o = 1'b1;
                IorD_o     = 1'b1;
                retired_o  = mem_ack_i;
                if (mem_ack_i) state_nxt = boundary;
            end

            EXEC: begin
                ALUSrcA_o = 1'b1;
                ALUOp_o   = 2'b10;
                state_nxt = RWB;
            end

            RWB: begin
                RegDst_o   = 1'b1;
                RegWrite_o = 1'b1;
                retired_o  = 1'b1;
                state_nxt  = boundary;
            end

            BRANCH: begin
                ALUSrcA_o  = 1'b1;
                ALUOp_o    = 2'b01;
                PCSource_o = 2'b01;
                PCWrite_o  = Zero_i;
                retired_o  = 1'b1;
                state_nxt  = boundary;
            end

            JUMP: begin
                PCSource_o = 2'b10;
                PCWrite_o  = 1'b1;
                retired_o  = 1'b1;
                state_nxt  = boundary;
            end

            ADDI_EX: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = 2'b10;
                state_nxt = ADDI_WB;
            end

            ADDI_WB: begin
                RegWrite_o = 1'b1;
                retired_o  = 1'b1;
                state_nxt  = boundary;
            end

            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: cycle-by-cycle vector table through a scoreboard queue,
// then randomized wait-state latency sequences.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst, start, zero, ack;
    logic [5:0] op;
    logic       pcw, iord, mrd, mwr, irw, rdst, m2r, rwr, srca, ret, ill;
    logic [1:0] srcb, aluop, pcsrc;
    logic [3:0] st;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .Op_i(op), .Zero_i(zero), .mem_ack_i(ack),
        .PCWrite_o(pcw), .IorD_o(iord), .MemRead_o(mrd), .MemWrite_o(mwr), .IRWrite_o(irw),
        .RegDst_o(rdst), .MemtoReg_o(m2r), .RegWrite_o(rwr), .ALUSrcA_o(srca),
        .ALUSrcB_o(srcb), .ALUOp_o(aluop), .PCSource_o(pcsrc), .retired_o(ret),
        .illegal_o(ill), .state_o(st)
    );

    localparam logic [5:0] R = 6'b000000, ADDI = 6'b001000, LW = 6'b100011;
    localparam logic [5:0] SW = 6'b101011, BEQ = 6'b000100, J = 6'b000010, BAD = 6'b111111;

    function automatic logic [16:0] mk(input logic pw, io, mr, mw, ir, rd, mt, rw, sa,
                                       input logic [1:0] sb, ao, ps, input logic rt, il);
        return {pw, io, mr, mw, ir, rd, mt, rw, sa, sb, ao, ps, rt, il};
    endfunction

    logic [16:0] o_idle, o_f0, o_f1, o_dec, o_dec_ill, o_ma, o_mr, o_mwb, o_mw0, o_mw1;
    logic [16:0] o_ex, o_rwb, o_brz, o_brnz, o_j, o_ae, o_aw;

    typedef struct {
        logic        rst, start;
        logic [5:0]  op;
        logic        zero, ack, chk;
        logic [3:0]  st;
        logic [16:0] out;
    } vec_t;

    typedef struct {
        int          idx;
        logic [3:0]  st;
        logic [16:0] out;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];

    function automatic logic [16:0] dut_out();
        return {pcw, iord, mrd, mwr, irw, rdst, m2r, rwr, srca, srcb, aluop, pcsrc, ret, ill};
    endfunction

    task automatic add(input logic r, s, input logic [5:0] o, input logic z, a, c,
                       input logic [3:0] es, input logic [16:0] eo);
        vec_t v;
        v.rst = r; v.start = s; v.op = o; v.zero = z; v.ack = a; v.chk = c;
        v.st = es; v.out = eo;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act, exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s @%0d: got %h expected %h", name, idx, act, exp_v);
        end
    endtask

    // Run one instruction from IDLE with fw FETCH waits and mw memory waits; start drops
    // as soon as FETCH is entered, so the instruction must still finish then park.
    task automatic run_instr(input logic [5:0] o, input int fw, mw, base_lat);
        int mstart, exp_ret, nret, ret_at;
        mstart  = fw + 3;
        exp_ret = base_lat - 1 + fw + mw;
        nret = 0; ret_at = -1;
        @(posedge clk); #1;
        rst = 0; start = 1; op = o; zero = 0; ack = 0;
        for (int i = 0; i <= exp_ret + 2; i++) begin
            @(posedge clk); #1;
            start = 0;
            ack = !((i < fw) || (i >= mstart && i < mstart + mw));
            @(negedge clk);
            if (i < fw) check("fetch_wait_memread", i, {31'd0, mrd}, 32'd1);
            if (ret) begin nret++; ret_at = i; end
        end
        check("retire_count", fw, nret, 1);
        check("retire_cycle", mw, ret_at, exp_ret);
        check("parked_idle", exp_ret, {28'd0, st}, 32'd0);
    endtask

    initial begin
        o_idle    = '0;
        o_f0      = mk(0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0);
        o_f1      = mk(1,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0,0);
        o_dec     = mk(0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0);
        o_dec_ill = mk(0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,1);
        o_ma      = mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0);
        o_mr      = mk(0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0);
        o_mwb     = mk(0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,1,0);
        o_mw0     = mk(0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0);
        o_mw1     = mk(0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,1,0);
        o_ex      = mk(0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,0);
        o_rwb     = mk(0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,1,0);
        o_brz     = mk(1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,1,0);
        o_brnz    = mk(0,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,1,0);
        o_j       = mk(1,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1,0);
        o_ae      = mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0);
        o_aw      = mk(0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,1,0);

        //   rst st  op   z  ack chk  state  outputs
        add(1, 0, R,   0, 0, 0, 4'd0,  o_idle);
        add(1, 0, R,   0, 0, 1, 4'd0,  o_idle);
        add(0, 0, R,   0, 1, 1, 4'd0,  o_idle);
        add(0, 1, R,   0, 1, 1, 4'd0,  o_idle);
        // R-type, ack always high
        add(0, 1, R,   0, 1, 1, 4'd1,  o_f1);
        add(0, 1, R,   0, 1, 1, 4'd2,  o_dec);
        add(0, 1, R,   0, 1, 1, 4'd7,  o_ex);
        add(0, 1, R,   0, 1, 1, 4'd8,  o_rwb);
        // lw: two FETCH waits, one MEMREAD wait
        add(0, 1, LW,  0, 0, 1, 4'd1,  o_f0);
        add(0, 1, LW,  0, 0, 1, 4'd1,  o_f0);
        add(0, 1, LW,  0, 1, 1, 4'd1,  o_f1);
        add(0, 1, LW,  0, 1, 1, 4'd2,  o_dec);
        add(0, 1, LW,  0, 1, 1, 4'd3,  o_ma);
        add(0, 1, LW,  0, 0, 1, 4'd4,  o_mr);
        add(0, 1, LW,  0, 1, 1, 4'd4,  o_mr);
        add(0, 1, LW,  0, 1, 1, 4'd5,  o_mwb);
        // beq taken (ack low in DECODE must be ignored), then not taken
        add(0, 1, BEQ, 1, 1, 1, 4'd1,  o_f1);
        add(0, 1, BEQ, 1, 0, 1, 4'd2,  o_dec);
        add(0, 1, BEQ, 1, 0, 1, 4'd9,  o_brz);
        add(0, 1, BEQ, 0, 1, 1, 4'd1,  o_f1);
        add(0, 1, BEQ, 0, 1, 1, 4'd2,  o_dec);
        add(0, 1, BEQ, 0, 1, 1, 4'd9,  o_brnz);
        // j, addi
        add(0, 1, J,   0, 1, 1, 4'd1,  o_f1);
        add(0, 1, J,   0, 1, 1, 4'd2,  o_dec);
        add(0, 1, J,   0, 0, 1, 4'd10, o_j);
        add(0, 1, ADDI,0, 1, 1, 4'd1,  o_f1);
        add(0, 1, ADDI,0, 1, 1, 4'd2,  o_dec);
        add(0, 1, ADDI,0, 1, 1, 4'd11, o_ae);
        add(0, 1, ADDI,0, 1, 1, 4'd12, o_aw);
        // illegal opcode acts as NOP, refetch
        add(0, 1, BAD, 0, 1, 1, 4'd1,  o_f1);
        add(0, 1, BAD, 0, 1, 1, 4'd2,  o_dec_ill);
        // sw with start dropped in MEMADDR
        add(0, 1, SW,  0, 1, 1, 4'd1,  o_f1);
        add(0, 1, SW,  0, 1, 1, 4'd2,  o_dec);
        add(0, 0, SW,  0, 1, 1, 4'd3,  o_ma);
        add(0, 0, SW,  0, 0, 1, 4'd6,  o_mw0);
        add(0, 0, SW,  0, 1, 1, 4'd6,  o_mw1);
        add(0, 0, SW,  0, 1, 1, 4'd0,  o_idle);
        add(0, 0, SW,  0, 1, 1, 4'd0,  o_idle);
        // reset during a MEMWRITE wait
        add(0, 1, SW,  0, 1, 1, 4'd0,  o_idle);
        add(0, 1, SW,  0, 1, 1, 4'd1,  o_f1);
        add(0, 1, SW,  0, 1, 1, 4'd2,  o_dec);
        add(0, 1, SW,  0, 1, 1, 4'd3,  o_ma);
        add(0, 1, SW,  0, 0, 1, 4'd6,  o_mw0);
        add(1, 1, SW,  0, 0, 1, 4'd6,  o_mw0);
        add(0, 0, SW,  0, 1, 1, 4'd0,  o_idle);
        add(0, 0, SW,  0, 1, 1, 4'd0,  o_idle);

        rst = 1; start = 0; op = '0; zero = 0; ack = 0;
        foreach (vecs[i]) begin
            exp_t e;
            @(posedge clk); #1;
            rst = vecs[i].rst; start = vecs[i].start; op = vecs[i].op;
            zero = vecs[i].zero; ack = vecs[i].ack;
            if (vecs[i].chk) begin
                e.idx = i; e.st = vecs[i].st; e.out = vecs[i].out;
                sb_q.push_back(e);
            end
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("state", e.idx, {28'd0, st}, {28'd0, e.st});
                check("outputs", e.idx, {15'd0, dut_out()}, {15'd0, e.out});
            end
        end
        check("scoreboard_drained", 0, sb_q.size(), 0);

        // Randomized wait-state latency sequences from IDLE.
        for (int k = 0; k < 4; k++) begin
            int fw, mw;
            fw = $urandom_range(0, 3);
            mw = $urandom_range(0, 3);
            run_instr(LW, fw, mw, 5);
            run_instr(SW, fw, mw, 4);
            run_instr(R,  fw, 0,  4);
            run_instr(BEQ, fw, 0, 3);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish within bound");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Finite-state controller that sequences the shared multi-cycle MIPS datapath: one ALU, one unified instruction/data memory, one register file, and IR/ALUOut/PC registers. Decodes the opcode held in the instruction register and drives every datapath select and write enable, one state per cycle. Memory accesses stall on a ready handshake. It sits beside the datapath in the CPU top level, in the place the single-cycle combinational Control occupies, and feeds ALU_Control through ALUOp_o.

## Interface
Parameters: none. Opcodes are fixed:
- R-type 000000
- addi 001000
- lw 100011
- sw 101011
- beq 000100
- j 000010

Ports (clock and reset first):
- clk_i  in  1  sole clock; all state changes on its rising edge
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  run enable, level-sensitive
- Op_i  in  6  instr[31:26] from the instruction register
- Zero_i  in  1  ALU zero flag
- mem_ack_i  in  1  memory has completed the current read or write this cycle
- PCWrite_o  out  1  load PC
- IorD_o  out  1  memory address source: 0 = PC, 1 = ALUOut
- MemRead_o  out  1  memory read request
- MemWrite_o  out  1  memory write request
- IRWrite_o  out  1  load instruction register
- RegDst_o  out  1  write register select: 0 = rt, 1 = rd
- MemtoReg_o  out  1  write data select: 0 = ALUOut, 1 = memory data register
- RegWrite_o  out  1  register file write enable
- ALUSrcA_o  out  1  ALU operand A select: 0 = PC, 1 = rs data
- ALUSrcB_o  out  2  ALU operand B select: 00 = rt data, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm<<2
- ALUOp_o  out  2  ALU operation: 00 = add, 01 = sub, 10 = decode funct
- PCSource_o  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = {PC[31:28], instr[25:0], 2'b00}
- retired_o  out  1  one-cycle pulse when an instruction completes
- illegal_o  out  1  one-cycle pulse when DECODE sees an unsupported opcode
- state_o  out  4  current state encoding, for debug

## Operation
- State register: 4 bits. Outputs are combinational from state, Op_i, Zero_i and mem_ack_i.
- Every output and field not listed for a state is 0.
- State encodings and outputs:
  - IDLE=0: all outputs 0.
  - FETCH=1: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite = PCWrite = mem_ack_i.
  - DECODE=2: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut).
  - MEMADDR=3: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - MEMREAD=4: MemRead=1, IorD=1.
  - MEMWB=5: RegDst=0, MemtoReg=1, RegWrite=1, retired=1.
  - MEMWRITE=6: MemWrite=1, IorD=1; retired = mem_ack_i.
  - EXEC=7: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - RWB=8: RegDst=1, MemtoReg=0, RegWrite=1, retired=1.
  - BRANCH=9: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01, PCWrite=Zero_i, retired=1.
  - JUMP=10: PCSource=10, PCWrite=1, retired=1.
  - ADDI_EX=11: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - ADDI_WB=12: RegDst=0, MemtoReg=0, RegWrite=1, retired=1.
- Transitions:
  - IDLE -> FETCH when start_i=1; otherwise stay in IDLE.
  - FETCH -> DECODE on mem_ack_i; otherwise stay (wait state).
  - DECODE by opcode: lw/sw -> MEMADDR; R-type -> EXEC; addi -> ADDI_EX; beq -> BRANCH; j -> JUMP.
  - DECODE on any other opcode: illegal_o=1, then go to the boundary target (instruction treated as NOP; PC already advanced).
  - MEMADDR -> MEMREAD (lw) or MEMWRITE (sw).
  - MEMREAD -> MEMWB on mem_ack_i; otherwise stay.
  - EXEC -> RWB.
  - ADDI_EX -> ADDI_WB.
  - Completing states (MEMWB, RWB, BRANCH, JUMP, ADDI_WB, and MEMWRITE on ack) -> boundary target.
- Boundary target: FETCH if start_i=1 in that cycle, else IDLE.
- Dropping start_i mid-instruction never aborts the instruction. The instruction always completes before the controller idles.
- Unused encodings 13-15 -> IDLE next cycle, all outputs 0.

## Timing
- Reset, checked on the clock edge: state=IDLE. Every output is 0 in the following cycle, including retired_o, illegal_o and state_o.
- rst_i has priority over all transitions, including in mid-instruction or memory-wait states. No write strobe is asserted in the cycle after reset.
- Latency from entering FETCH to retired_o, with mem_ack_i high on first request:
  - beq and j: 3 cycles
  - R-type, addi and sw: 4 cycles
  - lw: 5 cycles
- Each cycle mem_ack_i is low in FETCH, MEMREAD or MEMWRITE adds one cycle.
- MemRead_o and MemWrite_o stay high and stable for the whole wait. Address select stays constant while waiting.
- mem_ack_i is ignored in every other state.
- IRWrite_o and PCWrite_o in FETCH assert exactly once per instruction, in the ack cycle.
- Back-to-back instructions with start_i high have no idle cycle: the cycle after a completion is FETCH.
- Op_i is sampled only in DECODE and MEMADDR. The IR holds it stable from the FETCH ack onward.

## Test plan
- rst_i=1 for 2 cycles, start_i=0 -> state_o=0 and all outputs 0. start_i=1 -> FETCH (1) next cycle, MemRead_o=1.
- R-type (Op 000000), ack always 1 -> state sequence 1,2,7,8,1; RegWrite_o=1 and RegDst_o=1 only in state 8; retired_o pulses once.
- lw with ack low for 2 cycles in FETCH and 1 cycle in MEMREAD -> sequence 1,1,1,2,3,4,4,5. IRWrite_o high only in the third FETCH cycle; MemtoReg_o=1 in state 5.
- beq with Zero_i=1, then again with Zero_i=0 -> PCWrite_o=1 with PCSource_o=01 in the first BRANCH, 0 in the second; both take 3 cycles.
- Op 111111 -> illegal_o pulses in DECODE, no RegWrite/MemWrite asserted, next state FETCH. sw followed by start_i dropped during MEMADDR -> MEMWRITE completes on ack, then IDLE.
- rst_i asserted while waiting in MEMWRITE with ack=0 -> next cycle state_o=0, MemWrite_o=0, retired_o never pulses.
